// File: rtl/bp_io_load_arbiter.sv
// Two-requester front end for the unicore's inbound I/O port. It arbitrates commands
// round-robin, keeps a credit count per requester and routes responses back by lce_id.
module bp_io_load_arbiter #(
  parameter int msg_width_p       = 128,
  parameter int lce_id_width_p    = 2,
  parameter int lce_id_offset_p   = 0,
  parameter int req1_lce_id_p     = 3,
  parameter int max_outstanding_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [msg_width_p-1:0] req0_cmd_i,
  input  logic                   req0_cmd_v_i,
  output logic                   req0_cmd_yumi_o,
  input  logic [msg_width_p-1:0] req1_cmd_i,
  input  logic                   req1_cmd_v_i,
  output logic                   req1_cmd_yumi_o,
  output logic [msg_width_p-1:0] cmd_o,
  output logic                   cmd_v_o,
  input  logic                   cmd_yumi_i,
  input  logic [msg_width_p-1:0] resp_i,
  input  logic                   resp_v_i,
  output logic                   resp_ready_and_o,
  output logic [msg_width_p-1:0] resp0_o,
  output logic                   resp0_v_o,
  input  logic                   resp0_ready_and_i,
  output logic [msg_width_p-1:0] resp1_o,
  output logic                   resp1_v_o,
  input  logic                   resp1_ready_and_i,
  output logic                   error_o
);
  localparam int cnt_w = $clog2(max_outstanding_p + 1);
  localparam logic [cnt_w-1:0] max_cnt = cnt_w'(max_outstanding_p);
  localparam logic [lce_id_width_p-1:0] req1_id = lce_id_width_p'(req1_lce_id_p);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

  state_e           state, state_n;
  logic             last_grant, last_grant_n;
  logic [cnt_w-1:0] cnt0, cnt1;
  logic             error_r;
  logic             elig0, elig1, inc0, inc1, dec0, dec1, err_fsm;
  logic             cmd_v, yumi0, yumi1, dest, resp_rdy;

  assign elig0 = req0_cmd_v_i & (cnt0 < max_cnt);
  assign elig1 = req1_cmd_v_i & (cnt1 < max_cnt);

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    inc0         = 1'b0;
    inc1         = 1'b0;
    err_fsm      = 1'b0;
    cmd_o        = '0;
    cmd_v        = 1'b0;
    yumi0        = 1'b0;
    yumi1        = 1'b0;
    case (state)
      IDLE: begin
        // On a tie, the requester that was not served last time gets the grant.
        if (elig0 && elig1) state_n = last_grant ? GRANT0 : GRANT1;
        else if (elig0)     state_n = GRANT0;
        else if (elig1)     state_n = GRANT1;
      end
      GRANT0: begin
        cmd_o = req0_cmd_i;
        cmd_v = req0_cmd_v_i;
        if (!req0_cmd_v_i) begin
          state_n = IDLE;
          err_fsm = 1'b1;
        end else if (cmd_yumi_i) begin
          yumi0        = 1'b1;
          inc0         = 1'b1;
          last_grant_n = 1'b0;
          state_n      = IDLE;
        end
      end
      GRANT1: begin
        cmd_o = req1_cmd_i;
        cmd_v = req1_cmd_v_i;
        if (!req1_cmd_v_i) begin
          state_n = IDLE;
          err_fsm = 1'b1;
        end else if (cmd_yumi_i) begin
          yumi1        = 1'b1;
          inc1         = 1'b1;
          last_grant_n = 1'b1;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs are gated by reset so they are low for the whole reset assertion.
  assign cmd_v_o         = cmd_v & reset_n_i;
  assign req0_cmd_yumi_o = yumi0 & reset_n_i;
  assign req1_cmd_yumi_o = yumi1 & reset_n_i;

  assign dest             = (resp_i[lce_id_offset_p +: lce_id_width_p] == req1_id);
  assign resp_rdy         = dest ? resp1_ready_and_i : resp0_ready_and_i;
  assign resp_ready_and_o = resp_rdy & reset_n_i;
  assign resp0_o          = resp_i;
  assign resp1_o          = resp_i;
  assign resp0_v_o        = resp_v_i & ~dest & reset_n_i;
  assign resp1_v_o        = resp_v_i & dest & reset_n_i;
  assign dec0             = resp_v_i & ~dest & resp_rdy;
  assign dec1             = resp_v_i & dest & resp_rdy;
  assign error_o          = error_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt0       <= '0;
      cnt1       <= '0;
      error_r    <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      // A response with no credit outstanding is an error; the count holds at zero.
      if (inc0 && !dec0)                     cnt0 <= cnt0 + 1'b1;
      else if (dec0 && !inc0 && cnt0 != '0)  cnt0 <= cnt0 - 1'b1;
      if (inc1 && !dec1)                     cnt1 <= cnt1 + 1'b1;
      else if (dec1 && !inc1 && cnt1 != '0)  cnt1 <= cnt1 - 1'b1;
      error_r <= error_r | err_fsm | (dec0 && cnt0 == '0) | (dec1 && cnt1 == '0);
    end
  end
endmodule
